// File: rtl/bit_serial_alu.sv
// Bit-serial ALU execute stage: one operand bit pair per clock, LSB first,
// through the XOR sum path into a shift register; commits result/flags on done.
module bit_serial_alu #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_PASS = 3'b110,
    OP_NOT  = 3'b111
  } op_t;

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  logic             b_eff;
  logic             res_bit;
  logic             c_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      shift_q  <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  // Per-bit datapath; operand registers shift right so bit 0 is always current.
  always_comb begin
    b_eff   = (op_q == OP_SUB) ? ~b_q[0] : b_q[0];
    res_bit = 1'b0;
    c_nx    = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        res_bit = a_q[0] ^ b_eff ^ c_q;
        c_nx    = (a_q[0] & b_eff) | (a_q[0] & c_q) | (b_eff & c_q);
      end
      OP_AND:  res_bit = a_q[0] & b_q[0];
      OP_OR:   res_bit = a_q[0] | b_q[0];
      OP_XOR:  res_bit = a_q[0] ^ b_q[0];
      OP_XNOR: res_bit = ~(a_q[0] ^ b_q[0]);
      OP_PASS: res_bit = a_q[0];
      default: res_bit = ~a_q[0];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op_t'(op);
          a_d     = a;
          b_d     = b;
          cnt_d   = '0;
          c_d     = (op == 3'b001);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        shift_d = {res_bit, shift_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        c_d     = c_nx;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = S_DONE;
          result_d = shift_d;
          carry_d  = c_nx;
          zero_d   = (shift_d == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy   = (state_q == S_EXEC);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_bit_serial_alu.sv
// Directed bench for bit_serial_alu: expected results queued at accept,
// popped and compared whenever done is seen.
module tb_bit_serial_alu;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op = 3'b000;
  logic [3:0] a = 4'h0;
  logic [3:0] b = 4'h0;
  logic       busy, done, carry, zero;
  logic [3:0] result;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] res;
    logic       c;
    logic       z;
    string      tag;
  } exp_t;

  exp_t sb[$];

  bit_serial_alu #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .carry  (carry),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] er, input logic ec, input string tag);
    exp_t e;
    e.res = er;
    e.c   = ec;
    e.z   = (er == 4'h0);
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: every done pulse must match the oldest queued op.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("done_unexpected", {31'd0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_result"}, {28'd0, result}, {28'd0, e.res});
        check({e.tag, "_carry"},  {31'd0, carry},  {31'd0, e.c});
        check({e.tag, "_zero"},   {31'd0, zero},   {31'd0, e.z});
      end
    end
  end

  // One operation: start for one cycle, then walk E..E+5 checking busy/done.
  task automatic run_op(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y,
                        input logic [3:0] er, input logic ec, input string tag,
                        input bit scramble = 1'b0, input bit poke_done = 1'b0);
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    push(er, ec, tag);
    @(posedge clk);
    #1 start = 1'b0;
    for (int unsigned i = 0; i <= 5; i++) begin
      @(negedge clk);
      check($sformatf("%s_busy%0d", tag, i), {31'd0, busy}, {31'd0, (i < 4)});
      check($sformatf("%s_done%0d", tag, i), {31'd0, done}, {31'd0, (i == 4)});
      if (scramble && i == 1) begin
        a  = 4'hF;
        b  = 4'hF;
        op = 3'b111;
      end
      if (poke_done && i == 4) start = 1'b1;
      if (poke_done && i == 5) start = 1'b0;
    end
    if (poke_done) begin
      for (int unsigned i = 0; i < 3; i++) begin
        @(negedge clk);
        check($sformatf("%s_ignored_busy%0d", tag, i), {31'd0, busy}, 32'd0);
      end
    end
  endtask

  initial begin
    // reset and idle
    #1;
    check("rst_busy",   {31'd0, busy},   32'd0);
    check("rst_done",   {31'd0, done},   32'd0);
    check("rst_result", {28'd0, result}, 32'd0);
    check("rst_carry",  {31'd0, carry},  32'd0);
    check("rst_zero",   {31'd0, zero},   32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("idle_outs%0d", i), {25'd0, busy, done, carry, zero, result}, 32'd0);
    end

    // ADD
    run_op(3'b000, 4'b0111, 4'b1001, 4'b0000, 1'b1, "add_wrap");
    run_op(3'b000, 4'b0011, 4'b0100, 4'b0111, 1'b0, "add_small");

    // SUB
    run_op(3'b001, 4'b0011, 4'b0101, 4'b1110, 1'b0, "sub_borrow");
    run_op(3'b001, 4'b0101, 4'b0011, 4'b0010, 1'b1, "sub_noborrow");
    run_op(3'b001, 4'b0110, 4'b0110, 4'b0000, 1'b1, "sub_equal");

    // logic ops
    run_op(3'b100, 4'b1010, 4'b0110, 4'b1100, 1'b0, "xor");
    run_op(3'b101, 4'b1010, 4'b0110, 4'b0011, 1'b0, "xnor");
    run_op(3'b010, 4'b1010, 4'b0110, 4'b0010, 1'b0, "and");
    run_op(3'b011, 4'b1010, 4'b0110, 4'b1110, 1'b0, "or");
    run_op(3'b110, 4'b1010, 4'b0110, 4'b1010, 1'b0, "pass");
    run_op(3'b111, 4'b1010, 4'b0110, 4'b0101, 1'b0, "not");

    // start held high: accepts every 6 cycles
    @(negedge clk);
    start = 1'b1;
    op = 3'b000;
    a = 4'b0001;
    b = 4'b0001;
    push(4'b0010, 1'b0, "hold0");
    push(4'b0010, 1'b0, "hold1");
    push(4'b0010, 1'b0, "hold2");
    @(posedge clk);
    for (int unsigned n = 0; n < 18; n++) begin
      @(negedge clk);
      check($sformatf("hold_busy%0d", n), {31'd0, busy}, {31'd0, ((n % 6) < 4)});
      check($sformatf("hold_done%0d", n), {31'd0, done}, {31'd0, ((n % 6) == 4)});
      if (n == 12) start = 1'b0;
    end

    // operand changes in flight, and start seen only in DONE
    run_op(3'b000, 4'b0001, 4'b0001, 4'b0010, 1'b0, "scramble", 1'b1, 1'b0);
    run_op(3'b000, 4'b0001, 4'b0010, 4'b0011, 1'b0, "poke_done", 1'b0, 1'b1);

    // reset mid-op
    run_op(3'b110, 4'b0101, 4'b0000, 4'b0101, 1'b0, "pre_abort");
    @(negedge clk);
    start = 1'b1;
    op = 3'b000;
    a = 4'b1111;
    b = 4'b0001;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_result", {28'd0, result}, 32'd0);
    check("abort_flags",  {29'd0, busy, carry, zero}, 32'd0);
    check("abort_done",   {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int unsigned i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("abort_quiet%0d", i), {25'd0, busy, done, carry, zero, result}, 32'd0);
    end
    run_op(3'b001, 4'b1000, 4'b0001, 4'b0111, 1'b1, "post_abort_sub");

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
